// File: rtl/barrido_sweep.sv
// Single-pattern march sweep: writes STUCK_VALUE to every word, then reads each
// word back and classifies mismatches as high-half-only or low-half errors.
module barrido_sweep #(
  parameter int                N_WORDS     = 1 << 20,
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1,
  parameter logic [DATA_W-1:0] STUCK_VALUE = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              done_write,
  output logic              done_read,
  output logic              read_phase,
  output logic              all_done,
  output logic [ADDR_W-1:0] addr_out,
  output logic [1:0]        error_type
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   cnt_r;
  logic                we_r;
  logic [DATA_W-1:0]   din_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W-1:0]   addr_out_r;
  logic                done_write_r;
  logic                done_read_r;
  logic                read_phase_r;
  logic                all_done_r;
  logic [ADDR_W-1:0]   cnt_next_s;

  // A low-half mismatch dominates, so 2'b11 can never be produced.
  function automatic logic [1:0] classify(input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] diff;
    diff = data ^ STUCK_VALUE;
    if (|diff[DATA_W/2-1:0]) begin
      classify = 2'b10;
    end else if (|diff[DATA_W-1:DATA_W/2]) begin
      classify = 2'b01;
    end else begin
      classify = 2'b00;
    end
  endfunction

  assign cnt_next_s = cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Sweep FSM; outputs are computed for the cycle the next state occupies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      we_r         <= 1'b0;
      din_r        <= '0;
      addr_r       <= '0;
      addr_out_r   <= '0;
      done_write_r <= 1'b0;
      done_read_r  <= 1'b0;
      read_phase_r <= 1'b0;
      all_done_r   <= 1'b0;
    end else begin
      we_r         <= 1'b0;
      din_r        <= '0;
      addr_r       <= '0;
      addr_out_r   <= '0;
      done_write_r <= 1'b0;
      done_read_r  <= 1'b0;
      read_phase_r <= 1'b0;
      all_done_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (start) begin
            state_r <= WRITE;
            we_r    <= 1'b1;
            din_r   <= STUCK_VALUE;
          end else begin
            state_r <= IDLE;
          end
        end
        WRITE: begin
          if (!start) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else if (cnt_r == LAST) begin
            state_r      <= READ;
            cnt_r        <= '0;
            read_phase_r <= 1'b1;
            done_write_r <= 1'b1;
          end else begin
            cnt_r  <= cnt_next_s;
            addr_r <= cnt_next_s;
            we_r   <= 1'b1;
            din_r  <= STUCK_VALUE;
          end
        end
        READ: begin
          if (!start) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else if (cnt_r == LAST) begin
            state_r      <= DONE;
            cnt_r        <= '0;
            done_write_r <= 1'b1;
            done_read_r  <= 1'b1;
            all_done_r   <= 1'b1;
          end else begin
            cnt_r        <= cnt_next_s;
            addr_r       <= cnt_next_s;
            addr_out_r   <= cnt_next_s;
            read_phase_r <= 1'b1;
            done_write_r <= 1'b1;
          end
        end
        DONE: begin
          cnt_r <= '0;
          if (!start) begin
            state_r <= IDLE;
          end else begin
            state_r      <= DONE;
            done_write_r <= 1'b1;
            done_read_r  <= 1'b1;
            all_done_r   <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Classification follows the RAM read data within the same cycle.
  always_comb begin
    error_type = 2'b00;
    if (read_phase_r) begin
      error_type = classify(mem_dout);
    end else begin
      error_type = 2'b00;
    end
  end

  assign mem_write_enable = we_r;
  assign mem_din          = din_r;
  assign mem_addr         = addr_r;
  assign addr_out         = addr_out_r;
  assign done_write       = done_write_r;
  assign done_read        = done_read_r;
  assign read_phase       = read_phase_r;
  assign all_done         = all_done_r;

endmodule

// File: tb/tb_barrido_sweep.sv
// Directed bench: three sweep engines (all-1s/8 words, all-0s/8 words,
// all-1s/5 words) each driving a RAM model with per-word stuck-at masks.
module tb_barrido_sweep;

  logic        clk;
  logic        rst;
  logic        start      [3];
  logic [15:0] dout       [3];
  logic        we         [3];
  logic [15:0] din        [3];
  logic [2:0]  addr       [3];
  logic        done_write [3];
  logic        done_read  [3];
  logic        read_phase [3];
  logic        all_done   [3];
  logic [2:0]  addr_out   [3];
  logic [1:0]  error_type [3];

  logic [15:0] mem [3][8];
  logic [15:0] sa0 [3][8];
  logic [15:0] sa1 [3][8];

  int n_tests = 0;
  int n_fail  = 0;

  barrido_sweep #(.N_WORDS(8), .DATA_W(16), .STUCK_VALUE(16'hFFFF)) u_ones (
    .clk(clk), .rst(rst), .start(start[0]), .mem_dout(dout[0]),
    .mem_write_enable(we[0]), .mem_din(din[0]), .mem_addr(addr[0]),
    .done_write(done_write[0]), .done_read(done_read[0]), .read_phase(read_phase[0]),
    .all_done(all_done[0]), .addr_out(addr_out[0]), .error_type(error_type[0])
  );

  barrido_sweep #(.N_WORDS(8), .DATA_W(16), .STUCK_VALUE(16'h0000)) u_zeros (
    .clk(clk), .rst(rst), .start(start[1]), .mem_dout(dout[1]),
    .mem_write_enable(we[1]), .mem_din(din[1]), .mem_addr(addr[1]),
    .done_write(done_write[1]), .done_read(done_read[1]), .read_phase(read_phase[1]),
    .all_done(all_done[1]), .addr_out(addr_out[1]), .error_type(error_type[1])
  );

  barrido_sweep #(.N_WORDS(5), .DATA_W(16), .STUCK_VALUE(16'hFFFF)) u_five (
    .clk(clk), .rst(rst), .start(start[2]), .mem_dout(dout[2]),
    .mem_write_enable(we[2]), .mem_din(din[2]), .mem_addr(addr[2]),
    .done_write(done_write[2]), .done_read(done_read[2]), .read_phase(read_phase[2]),
    .all_done(all_done[2]), .addr_out(addr_out[2]), .error_type(error_type[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: synchronous write, combinational read through stuck-at masks.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (we[k]) mem[k][addr[k]] <= din[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      dout[k] = (mem[k][addr[k]] & ~sa0[k][addr[k]]) | sa1[k][addr[k]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_faults();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 8; a++) begin
        sa0[k][a] = 16'h0000;
        sa1[k][a] = 16'h0000;
      end
    end
  endtask

  // Full sweep on instance k; exp_et holds the expected 2-bit code per address.
  task automatic run(input int k, input int n, input logic [15:0] sv, input logic [15:0] exp_et);
    start[k] = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      check($sformatf("wr_we%0d[%0d]", k, i), we[k], 1);
      check($sformatf("wr_addr%0d[%0d]", k, i), addr[k], i);
      check($sformatf("wr_din%0d[%0d]", k, i), din[k], sv);
      check($sformatf("wr_dw%0d[%0d]", k, i), done_write[k], 0);
      step();
    end
    for (int i = 0; i < n; i++) begin
      check($sformatf("rd_phase%0d[%0d]", k, i), read_phase[k], 1);
      check($sformatf("rd_we%0d[%0d]", k, i), we[k], 0);
      check($sformatf("rd_addr%0d[%0d]", k, i), addr[k], i);
      check($sformatf("rd_aout%0d[%0d]", k, i), addr_out[k], i);
      check($sformatf("rd_dw%0d[%0d]", k, i), done_write[k], 1);
      check($sformatf("rd_dr%0d[%0d]", k, i), done_read[k], 0);
      check($sformatf("rd_et%0d[%0d]", k, i), error_type[k], exp_et[2*i +: 2]);
      step();
    end
    check($sformatf("done_dr%0d", k), done_read[k], 1);
    check($sformatf("done_all%0d", k), all_done[k], 1);
    check($sformatf("done_dw%0d", k), done_write[k], 1);
    check($sformatf("done_rp%0d", k), read_phase[k], 0);
    check($sformatf("done_et%0d", k), error_type[k], 0);
    check($sformatf("done_we%0d", k), we[k], 0);
    step();
    check($sformatf("hold_all%0d", k), all_done[k], 1);
    start[k] = 1'b0;
    step();
    check($sformatf("drop_all%0d", k), all_done[k], 0);
    check($sformatf("drop_dr%0d", k), done_read[k], 0);
    check($sformatf("drop_dw%0d", k), done_write[k], 0);
  endtask

  initial begin
    clear_faults();
    for (int k = 0; k < 3; k++) start[k] = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_we", we[0], 0);
    check("rst_din", din[0], 0);
    check("rst_addr", addr[0], 0);
    check("rst_flags", {done_write[0], done_read[0], read_phase[0], all_done[0]}, 0);
    check("rst_et", error_type[0], 0);
    #20;
    rst = 1'b1;
    step();

    // Fault-free all-1s sweep.
    run(0, 8, 16'hFFFF, 16'h0000);

    // Bit 15 stuck-at-0 at addr 3 -> high-half-only.
    sa0[0][3] = 16'h8000;
    run(0, 8, 16'hFFFF, 16'h0040);

    // Bit 0 stuck-at-1 at addr 5 with all-0s pattern -> low-half.
    sa1[1][5] = 16'h0001;
    run(1, 8, 16'h0000, 16'h0800);

    // Bits 14 and 2 stuck-at-0 at addr 0 -> low-half wins, never 11.
    clear_faults();
    sa0[0][0] = 16'h4004;
    run(0, 8, 16'hFFFF, 16'h0002);

    // Abort during READ at cnt=4, then a full restart.
    clear_faults();
    start[0] = 1'b1;
    step();
    repeat (12) step();
    check("abort_aout", addr_out[0], 4);
    start[0] = 1'b0;
    step();
    check("abort_rp", read_phase[0], 0);
    check("abort_dr", done_read[0], 0);
    check("abort_dw", done_write[0], 0);
    repeat (3) step();
    check("abort_dr_late", done_read[0], 0);
    run(0, 8, 16'hFFFF, 16'h0000);

    // Asynchronous reset mid-WRITE.
    start[0] = 1'b1;
    step();
    step();
    step();
    check("mid_we", we[0], 1);
    check("mid_addr", addr[0], 2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_we", we[0], 0);
    check("arst_addr", addr[0], 0);
    check("arst_din", din[0], 0);
    start[0] = 1'b0;
    #2;
    rst = 1'b1;
    step();
    run(0, 8, 16'hFFFF, 16'h0000);

    // Five-word sweep ends at addr 4 with no wrap.
    run(2, 5, 16'hFFFF, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
